// File: rtl/alu_operand_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_pkg
// Shared definitions for the ID/EX operand stage and the ALU behind it.
//   XLEN_DEFAULT / REG_AW_DEFAULT : default datapath and register-address widths
//   alu_op_e                      : ALUOP_* operation codes consumed by the ALU
//   fwd_sel_e                     : operand source chosen by the forwarding mux
// ---------------------------------------------------------------------------
package alu_operand_stage_pkg;

   localparam int XLEN_DEFAULT   = 32;
   localparam int REG_AW_DEFAULT = 5;

   typedef enum logic [2:0] {
      ALUOP_ADD  = 3'd0,
      ALUOP_OR   = 3'd1,
      ALUOP_SRL  = 3'd2,
      ALUOP_SLL  = 3'd3,
      ALUOP_SLTU = 3'd4,
      ALUOP_SUB  = 3'd5,
      ALUOP_SRC1 = 3'd6
   } alu_op_e;

   typedef enum logic [1:0] {
      SEL_HELD = 2'd0,
      SEL_WB   = 2'd1,
      SEL_MEM  = 2'd2
   } fwd_sel_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_if
// Bundles every bus that touches the operand stage:
//   flush                        : kill the held instruction
//   dec_*                        : decoded instruction offered by decode (valid/ready)
//   mem_* / wb_*                 : producer results available for forwarding
//   out_valid/out_ready, src_a, src_b, op_code, rd_addr, rd_we
//                                : operands handed to the ALU and EX/MEM
// Modports:
//   slave  : the operand stage itself
//   master : the surrounding pipeline (decode, producers, downstream)
// ---------------------------------------------------------------------------
interface alu_operand_stage_if #(
   parameter int XLEN   = alu_operand_stage_pkg::XLEN_DEFAULT,
   parameter int REG_AW = alu_operand_stage_pkg::REG_AW_DEFAULT
) ();
   import alu_operand_stage_pkg::*;

   logic              flush;

   logic              dec_valid;
   logic              dec_ready;
   logic [2:0]        dec_op_code;
   logic [REG_AW-1:0] dec_rs1_addr;
   logic [REG_AW-1:0] dec_rs2_addr;
   logic [XLEN-1:0]   dec_rs1_data;
   logic [XLEN-1:0]   dec_rs2_data;
   logic [XLEN-1:0]   dec_imm;
   logic              dec_use_imm;
   logic [REG_AW-1:0] dec_rd_addr;
   logic              dec_rd_we;

   logic              mem_rd_we;
   logic [REG_AW-1:0] mem_rd_addr;
   logic [XLEN-1:0]   mem_rd_data;
   logic              mem_is_load;

   logic              wb_rd_we;
   logic [REG_AW-1:0] wb_rd_addr;
   logic [XLEN-1:0]   wb_rd_data;

   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   src_a;
   logic [XLEN-1:0]   src_b;
   logic [2:0]        op_code;
   logic [REG_AW-1:0] rd_addr;
   logic              rd_we;

   modport slave (
      input  flush,
      input  dec_valid, dec_op_code, dec_rs1_addr, dec_rs2_addr, dec_rs1_data,
             dec_rs2_data, dec_imm, dec_use_imm, dec_rd_addr, dec_rd_we,
      output dec_ready,
      input  mem_rd_we, mem_rd_addr, mem_rd_data, mem_is_load,
      input  wb_rd_we, wb_rd_addr, wb_rd_data,
      input  out_ready,
      output out_valid, src_a, src_b, op_code, rd_addr, rd_we
   );

   modport master (
      output flush,
      output dec_valid, dec_op_code, dec_rs1_addr, dec_rs2_addr, dec_rs1_data,
             dec_rs2_data, dec_imm, dec_use_imm, dec_rd_addr, dec_rd_we,
      input  dec_ready,
      output mem_rd_we, mem_rd_addr, mem_rd_data, mem_is_load,
      output wb_rd_we, wb_rd_addr, wb_rd_data,
      output out_ready,
      input  out_valid, src_a, src_b, op_code, rd_addr, rd_we
   );

endinterface

// File: rtl/alu_operand_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_fwd_mux
// Hazard detect and priority select for one ALU source operand.
//   used        : this source is actually read by the instruction
//   rs_addr     : source register of the held instruction
//   held_data   : operand value currently held in the stage
//   mem_* / wb_*: producer buses
//   data        : forwarded operand
//   load_stall  : source depends on a load still in MEM
//   wb_hit      : WB is writing this source (used to refresh the held copy)
// ---------------------------------------------------------------------------
module alu_operand_stage_fwd_mux
   import alu_operand_stage_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int REG_AW = REG_AW_DEFAULT
) (
   input  logic              used,
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [XLEN-1:0]   held_data,
   input  logic              mem_rd_we,
   input  logic [REG_AW-1:0] mem_rd_addr,
   input  logic [XLEN-1:0]   mem_rd_data,
   input  logic              mem_is_load,
   input  logic              wb_rd_we,
   input  logic [REG_AW-1:0] wb_rd_addr,
   input  logic [XLEN-1:0]   wb_rd_data,
   output logic [XLEN-1:0]   data,
   output logic              load_stall,
   output logic              wb_hit
);

   logic     mem_hit;
   fwd_sel_e sel;

   // x0 is hardwired to zero, so a producer targeting it never forwards.
   assign mem_hit    = used && mem_rd_we && (mem_rd_addr != '0) && (mem_rd_addr == rs_addr);
   assign wb_hit     = used && wb_rd_we  && (wb_rd_addr  != '0) && (wb_rd_addr  == rs_addr);
   assign load_stall = mem_hit && mem_is_load;

   // MEM is the younger producer and wins; a load in MEM has no data yet,
   // so it falls through to WB/held while the stall holds the instruction.
   always_comb begin
      sel = SEL_HELD;
      if (mem_hit && !mem_is_load) begin
         sel = SEL_MEM;
      end else if (wb_hit) begin
         sel = SEL_WB;
      end
   end

   // Operand value for the selected source.
   always_comb begin
      data = held_data;
      case (sel)
         SEL_MEM: data = mem_rd_data;
         SEL_WB:  data = wb_rd_data;
         default: data = held_data;
      endcase
   end

endmodule

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
// ID/EX register sitting in front of the combinational ALU. Captures one
// decoded instruction, holds it under backpressure, forwards MEM/WB results
// onto src_a/src_b and interlocks on load-use hazards.
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : alu_operand_stage_if.slave (decode, producers, ALU-side outputs)
// ---------------------------------------------------------------------------
module alu_operand_stage
   import alu_operand_stage_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int REG_AW = REG_AW_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_operand_stage_if.slave   bus
);

   logic              hold_valid;
   alu_op_e           hold_op;
   logic [XLEN-1:0]   hold_a;
   logic [XLEN-1:0]   hold_b;
   logic [XLEN-1:0]   hold_imm;
   logic              hold_use_imm;
   logic [REG_AW-1:0] hold_rs1;
   logic [REG_AW-1:0] hold_rs2;
   logic [REG_AW-1:0] hold_rd;
   logic              hold_rd_we;

   logic [XLEN-1:0]   fwd_a;
   logic [XLEN-1:0]   fwd_b;
   logic              stall_a;
   logic              stall_b;
   logic              wb_hit_a;
   logic              wb_hit_b;

   logic              load_use;
   logic              out_valid;
   logic              fire_out;
   logic              dec_ready;
   logic              capture;
   logic [XLEN-1:0]   cap_a;
   logic [XLEN-1:0]   cap_b;

   alu_operand_stage_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_a (
      .used        (1'b1),
      .rs_addr     (hold_rs1),
      .held_data   (hold_a),
      .mem_rd_we   (bus.mem_rd_we),
      .mem_rd_addr (bus.mem_rd_addr),
      .mem_rd_data (bus.mem_rd_data),
      .mem_is_load (bus.mem_is_load),
      .wb_rd_we    (bus.wb_rd_we),
      .wb_rd_addr  (bus.wb_rd_addr),
      .wb_rd_data  (bus.wb_rd_data),
      .data        (fwd_a),
      .load_stall  (stall_a),
      .wb_hit      (wb_hit_a)
   );

   // With an immediate on b the rs2 field is meaningless, so no hazard on it.
   alu_operand_stage_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_b (
      .used        (!hold_use_imm),
      .rs_addr     (hold_rs2),
      .held_data   (hold_b),
      .mem_rd_we   (bus.mem_rd_we),
      .mem_rd_addr (bus.mem_rd_addr),
      .mem_rd_data (bus.mem_rd_data),
      .mem_is_load (bus.mem_is_load),
      .wb_rd_we    (bus.wb_rd_we),
      .wb_rd_addr  (bus.wb_rd_addr),
      .wb_rd_data  (bus.wb_rd_data),
      .data        (fwd_b),
      .load_stall  (stall_b),
      .wb_hit      (wb_hit_b)
   );

   // Handshake: a load-use hazard hides the instruction from downstream,
   // which in turn blocks decode because the slot cannot drain.
   assign load_use  = stall_a || stall_b;
   assign out_valid = hold_valid && !load_use;
   assign fire_out  = out_valid && bus.out_ready;
   assign dec_ready = !bus.flush && (!hold_valid || fire_out);
   assign capture   = bus.dec_valid && dec_ready;

   // The register file cannot return a value written in the same cycle, so
   // the retiring WB result is bypassed into the captured operands.
   always_comb begin
      cap_a = bus.dec_rs1_data;
      cap_b = bus.dec_rs2_data;
      if (bus.wb_rd_we && (bus.wb_rd_addr != '0) && (bus.wb_rd_addr == bus.dec_rs1_addr)) begin
         cap_a = bus.wb_rd_data;
      end
      if (bus.wb_rd_we && (bus.wb_rd_addr != '0) && (bus.wb_rd_addr == bus.dec_rs2_addr)) begin
         cap_b = bus.wb_rd_data;
      end
   end

   // Holding register. Flush beats capture beats drain; while an instruction
   // sits stalled, WB results are folded into the held operands so nothing is
   // lost once the producer retires out of WB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid   <= 1'b0;
         hold_op      <= ALUOP_ADD;
         hold_a       <= '0;
         hold_b       <= '0;
         hold_imm     <= '0;
         hold_use_imm <= 1'b0;
         hold_rs1     <= '0;
         hold_rs2     <= '0;
         hold_rd      <= '0;
         hold_rd_we   <= 1'b0;
      end else if (bus.flush) begin
         hold_valid   <= 1'b0;
      end else if (capture) begin
         hold_valid   <= 1'b1;
         hold_op      <= alu_op_e'(bus.dec_op_code);
         hold_a       <= cap_a;
         hold_b       <= cap_b;
         hold_imm     <= bus.dec_imm;
         hold_use_imm <= bus.dec_use_imm;
         hold_rs1     <= bus.dec_rs1_addr;
         hold_rs2     <= bus.dec_rs2_addr;
         hold_rd      <= bus.dec_rd_addr;
         hold_rd_we   <= bus.dec_rd_we;
      end else if (fire_out) begin
         hold_valid   <= 1'b0;
      end else if (hold_valid) begin
         if (wb_hit_a) begin
            hold_a <= bus.wb_rd_data;
         end
         if (wb_hit_b) begin
            hold_b <= bus.wb_rd_data;
         end
      end
   end

   assign bus.dec_ready = dec_ready;
   assign bus.out_valid = out_valid;
   assign bus.src_a     = fwd_a;
   assign bus.src_b     = hold_use_imm ? hold_imm : fwd_b;
   assign bus.op_code   = hold_op;
   assign bus.rd_addr   = hold_rd;
   assign bus.rd_we     = hold_rd_we;

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
// Directed self-checking bench for alu_operand_stage: handshake, forwarding
// priority, x0 guard, immediate operand, load-use interlock, operand refresh,
// capture-time WB bypass, backpressure, flush and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;
   import alu_operand_stage_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   alu_operand_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

   alu_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Offer one decoded instruction.
   task automatic applyStimulus(input logic [2:0] op, input logic [4:0] rs1, input logic [31:0] d1,
                                input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                                input logic use_imm, input logic [4:0] rd, input logic rd_we);
      bus.dec_valid    = 1'b1;
      bus.dec_op_code  = op;
      bus.dec_rs1_addr = rs1;
      bus.dec_rs1_data = d1;
      bus.dec_rs2_addr = rs2;
      bus.dec_rs2_data = d2;
      bus.dec_imm      = imm;
      bus.dec_use_imm  = use_imm;
      bus.dec_rd_addr  = rd;
      bus.dec_rd_we    = rd_we;
   endtask

   // Drive the MEM and WB producer buses.
   task automatic setForwarding(input logic mwe, input logic [4:0] maddr, input logic [31:0] mdata,
                                input logic mload, input logic wwe, input logic [4:0] waddr,
                                input logic [31:0] wdata);
      bus.mem_rd_we   = mwe;
      bus.mem_rd_addr = maddr;
      bus.mem_rd_data = mdata;
      bus.mem_is_load = mload;
      bus.wb_rd_we    = wwe;
      bus.wb_rd_addr  = waddr;
      bus.wb_rd_data  = wdata;
   endtask

   task automatic clearInputs();
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      applyStimulus(3'd0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      bus.dec_valid = 1'b0;
      setForwarding(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
   endtask

   // Advance to just after the next rising edge.
   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      checkOutput({tag, "_src_a"},     bus.src_a,          0);
      checkOutput({tag, "_src_b"},     bus.src_b,          0);
      checkOutput({tag, "_op_code"},   32'(bus.op_code),   0);
      checkOutput({tag, "_rd_addr"},   32'(bus.rd_addr),   0);
      checkOutput({tag, "_rd_we"},     32'(bus.rd_we),     0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      clearInputs();

      // Reset state.
      #2 rst = 1'b1;
      #6;
      checkAllZero("reset");
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("ready_after_reset", 32'(bus.dec_ready), 1);

      // Back-to-back ADD then SUB with out_ready high.
      bus.out_ready = 1'b1;
      applyStimulus(ALUOP_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 1'b0, 5'd3, 1'b1);
      stepClk();
      checkOutput("b2b_add_valid", 32'(bus.out_valid), 1);
      checkOutput("b2b_add_src_a", bus.src_a, 5);
      checkOutput("b2b_add_src_b", bus.src_b, 7);
      checkOutput("b2b_add_op",    32'(bus.op_code), 0);
      checkOutput("b2b_add_rd",    32'(bus.rd_addr), 3);
      checkOutput("b2b_add_rd_we", 32'(bus.rd_we), 1);
      applyStimulus(ALUOP_SUB, 5'd1, 32'd9, 5'd2, 32'd4, 32'h0, 1'b0, 5'd6, 1'b1);
      #1;
      checkOutput("b2b_ready_on_fire", 32'(bus.dec_ready), 1);
      stepClk();
      checkOutput("b2b_sub_valid", 32'(bus.out_valid), 1);
      checkOutput("b2b_sub_op",    32'(bus.op_code), 5);
      checkOutput("b2b_sub_src_a", bus.src_a, 9);
      checkOutput("b2b_sub_src_b", bus.src_b, 4);
      checkOutput("b2b_sub_rd",    32'(bus.rd_addr), 6);
      bus.dec_valid = 1'b0;
      stepClk();
      checkOutput("b2b_drained", 32'(bus.out_valid), 0);

      // MEM beats WB, WB beats held, and WB refreshes a stalled operand.
      bus.out_ready = 1'b0;
      applyStimulus(ALUOP_ADD, 5'd4, 32'h11, 5'd0, 32'h0, 32'h0, 1'b0, 5'd7, 1'b1);
      stepClk();
      bus.dec_valid = 1'b0;
      setForwarding(1'b1, 5'd4, 32'hAA, 1'b0, 1'b1, 5'd4, 32'h55);
      #1;
      checkOutput("mem_fwd_valid", 32'(bus.out_valid), 1);
      checkOutput("mem_fwd_src_a", bus.src_a, 32'hAA);
      setForwarding(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd4, 32'h55);
      #1;
      checkOutput("wb_fwd_src_a", bus.src_a, 32'h55);
      stepClk();
      setForwarding(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      #1;
      checkOutput("refresh_src_a", bus.src_a, 32'h55);
      bus.out_ready = 1'b1;
      stepClk();
      checkOutput("fwd_drained", 32'(bus.out_valid), 0);

      // x0 never forwards; immediate on b ignores rs2 hazards.
      bus.out_ready = 1'b0;
      applyStimulus(ALUOP_OR, 5'd0, 32'h0, 5'd5, 32'h99, 32'h20, 1'b1, 5'd8, 1'b1);
      stepClk();
      bus.dec_valid = 1'b0;
      setForwarding(1'b1, 5'd0, 32'hFF, 1'b0, 1'b1, 5'd0, 32'hEE);
      #1;
      checkOutput("x0_src_a", bus.src_a, 0);
      checkOutput("imm_src_b", bus.src_b, 32'h20);
      setForwarding(1'b1, 5'd5, 32'h77, 1'b1, 1'b0, 5'd0, 32'h0);
      #1;
      checkOutput("imm_no_stall_valid", 32'(bus.out_valid), 1);
      checkOutput("imm_no_fwd_src_b", bus.src_b, 32'h20);
      setForwarding(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      bus.out_ready = 1'b1;
      stepClk();
      checkOutput("imm_drained", 32'(bus.out_valid), 0);

      // Load-use on rs2, then WB delivers, then refresh under backpressure.
      bus.out_ready = 1'b1;
      applyStimulus(ALUOP_ADD, 5'd1, 32'd3, 5'd8, 32'hDEAD, 32'h0, 1'b0, 5'd9, 1'b1);
      stepClk();
      applyStimulus(ALUOP_SLL, 5'd2, 32'h40, 5'd3, 32'h50, 32'h0, 1'b0, 5'd10, 1'b1);
      setForwarding(1'b1, 5'd8, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
      #1;
      checkOutput("load_use_valid", 32'(bus.out_valid), 0);
      checkOutput("load_use_ready", 32'(bus.dec_ready), 0);
      stepClk();
      bus.out_ready = 1'b0;
      setForwarding(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd8, 32'h1234);
      #1;
      checkOutput("load_wb_valid", 32'(bus.out_valid), 1);
      checkOutput("load_wb_src_b", bus.src_b, 32'h1234);
      checkOutput("load_wb_src_a", bus.src_a, 3);
      stepClk();
      setForwarding(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      #1;
      checkOutput("refresh_src_b", bus.src_b, 32'h1234);

      // Backpressure: outputs stable and decode blocked.
      for (int i = 0; i < 3; i++) begin
         stepClk();
         checkOutput("bp_valid", 32'(bus.out_valid), 1);
         checkOutput("bp_src_b", bus.src_b, 32'h1234);
         checkOutput("bp_op",    32'(bus.op_code), 0);
         checkOutput("bp_rd",    32'(bus.rd_addr), 9);
         checkOutput("bp_ready", 32'(bus.dec_ready), 0);
      end

      // Flush with an instruction on offer: held one dies, offered one dropped.
      bus.flush     = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      checkOutput("flush_ready", 32'(bus.dec_ready), 0);
      stepClk();
      bus.flush     = 1'b0;
      bus.dec_valid = 1'b0;
      #1;
      checkOutput("flush_kill_valid", 32'(bus.out_valid), 0);
      checkOutput("flush_ready_after", 32'(bus.dec_ready), 1);

      // Capture-time WB bypass on rs2, then asynchronous reset mid-operation.
      bus.out_ready = 1'b0;
      applyStimulus(ALUOP_SLL, 5'd2, 32'h40, 5'd3, 32'h50, 32'h0, 1'b0, 5'd10, 1'b1);
      setForwarding(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd3, 32'h333);
      stepClk();
      bus.dec_valid = 1'b0;
      setForwarding(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      #1;
      checkOutput("cap_valid", 32'(bus.out_valid), 1);
      checkOutput("cap_op",    32'(bus.op_code), 3);
      checkOutput("cap_src_a", bus.src_a, 32'h40);
      checkOutput("cap_bypass_src_b", bus.src_b, 32'h333);
      #2 rst = 1'b1;
      #1;
      checkAllZero("async_reset");
      #3 rst = 1'b0;
      stepClk();
      checkOutput("post_reset_ready", 32'(bus.dec_ready), 1);
      checkOutput("post_reset_valid", 32'(bus.out_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
